// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters: accept in IDLE, drive ALU in EXEC, hold response in RESP.
module alu_arbiter #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op1,
  output logic              rsp_valid0,
  output logic              rsp_valid1,
  input  logic              rsp_ready0,
  input  logic              rsp_ready1,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              last;
  logic              owner;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [OP_W-1:0]   op_code;
  logic              rsp_v0;
  logic              rsp_v1;
  logic              busy_q;
  logic              grant0;
  logic              grant1;
  logic              consume;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req_valid0 && (!req_valid1 || last);
      grant1 = req_valid1 && (!req_valid0 || !last);
    end
  end

  assign consume = owner ? rsp_ready1 : rsp_ready0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_v0     <= 1'b0;
      rsp_v1     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a    <= grant1 ? req_a1  : req_a0;
            op_b    <= grant1 ? req_b1  : req_b0;
            op_code <= grant1 ? req_op1 : req_op0;
            owner   <= grant1;
            last    <= grant1;
            busy_q  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_v0     <= !owner;
          rsp_v1     <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (consume) begin
            rsp_v0 <= 1'b0;
            rsp_v1 <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;
  assign rsp_valid0 = rsp_v0;
  assign rsp_valid1 = rsp_v1;
  assign busy       = busy_q;
  assign alu_data1  = op_a;
  assign alu_data2  = op_b;
  assign alu_op     = op_code;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* port.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] a [2];
  logic [63:0] b [2];
  logic [3:0]  op [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_zero;
  logic        busy;
  logic [63:0] alu_data1;
  logic [63:0] alu_data2;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(64), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid[0]), .req_valid1(req_valid[1]),
    .req_ready0(req_ready[0]), .req_ready1(req_ready[1]),
    .req_a0(a[0]), .req_b0(b[0]), .req_op0(op[0]),
    .req_a1(a[1]), .req_b1(b[1]), .req_op1(op[1]),
    .rsp_valid0(rsp_valid[0]), .rsp_valid1(rsp_valid[1]),
    .rsp_ready0(rsp_ready[0]), .rsp_ready1(rsp_ready[1]),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_data1 & alu_data2;
      4'b0001: alu_result = alu_data1 | alu_data2;
      4'b0010: alu_result = alu_data1 + alu_data2;
      4'b0110: alu_result = alu_data1 - alu_data2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from a quiet IDLE: accept, EXEC, RESP, immediate consume.
  task automatic run_op(input int r, input logic [63:0] ra, input logic [63:0] rb,
                        input logic [3:0] rop, input logic [63:0] er, input logic ez);
    logic [1:0] m;
    m = 2'b01 << r;
    a[r] = ra; b[r] = rb; op[r] = rop; req_valid = m;
    #1;
    chk("accept_ready", {62'd0, req_ready}, {62'd0, m});
    tick();
    req_valid = 2'b00;
    chk("exec_busy", {63'd0, busy}, 64'd1);
    chk("exec_data1", alu_data1, ra);
    chk("exec_data2", alu_data2, rb);
    chk("exec_op", {60'd0, alu_op}, {60'd0, rop});
    chk("exec_no_rsp", {62'd0, rsp_valid}, 64'd0);
    tick();
    chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, m});
    chk("rsp_result", rsp_result, er);
    chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, ez});
    rsp_ready = m;
    tick();
    rsp_ready = 2'b00;
    chk("done_valid", {62'd0, rsp_valid}, 64'd0);
    chk("done_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    for (int unsigned i = 0; i < 2; i++) begin a[i] = '0; b[i] = '0; op[i] = '0; end
    #3;
    chk("rst_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_zero", {63'd0, rsp_zero}, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
    chk("rst_data1", alu_data1, 64'd0);
    #5 rst_n = 1'b1;
    tick();

    // Single ADD, then SUB to zero and SUB wrap on requester 1
    run_op(0, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0);
    run_op(1, 64'h1234, 64'h1234, 4'b0110, 64'd0, 1'b1);
    run_op(1, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Contention: last grant was 1, so order is 0,1,0,1
    a[0] = 64'hF0; b[0] = 64'h0F; op[0] = 4'b0000;
    a[1] = 64'hF0; b[1] = 64'h0F; op[1] = 4'b0001;
    req_valid = 2'b11;
    for (int unsigned k = 0; k < 4; k++) begin
      logic [1:0] g;
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_grant", {62'd0, req_ready}, {62'd0, g});
      tick();
      chk("rr_exec_ready", {62'd0, req_ready}, 64'd0);
      tick();
      chk("rr_rsp_owner", {62'd0, rsp_valid}, {62'd0, g});
      chk("rr_result", rsp_result, (g == 2'b01) ? 64'h00 : 64'hFF);
      chk("rr_zero", {63'd0, rsp_zero}, (g == 2'b01) ? 64'd1 : 64'd0);
      chk("rr_rsp_ready_blocked", {62'd0, req_ready}, 64'd0);
      rsp_ready = g;
      tick();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    #1;

    // Backpressure on requester 0 while requester 1 waits
    a[0] = 64'd3; b[0] = 64'd4; op[0] = 4'b0010;
    req_valid = 2'b01;
    #1;
    chk("bp_accept0", {62'd0, req_ready}, 64'd1);
    tick();
    a[1] = 64'hFF; b[1] = 64'h0F; op[1] = 4'b0000;
    req_valid = 2'b11;
    #1;
    chk("bp_exec_ready", {62'd0, req_ready}, 64'd0);
    tick();
    rsp_ready = 2'b10;
    for (int unsigned k = 0; k < 5; k++) begin
      chk("bp_valid", {62'd0, rsp_valid}, 64'd1);
      chk("bp_result", rsp_result, 64'd7);
      chk("bp_zero", {63'd0, rsp_zero}, 64'd0);
      chk("bp_ready", {62'd0, req_ready}, 64'd0);
      tick();
    end
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    tick();
    rsp_ready = 2'b00;
    chk("bp_accept1", {62'd0, req_ready}, 64'd2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("bp_rsp1_valid", {62'd0, rsp_valid}, 64'd2);
    chk("bp_rsp1_result", rsp_result, 64'h0F);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;

    // Unsupported op returns result 0, zero 1
    run_op(0, '1, '1, 4'b0111, 64'd0, 1'b1);

    // Async reset while in RESP
    a[0] = 64'd10; b[0] = 64'd20; op[0] = 4'b0010; req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    chk("ar_pre_valid", {62'd0, rsp_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {62'd0, rsp_valid}, 64'd0);
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_result", rsp_result, 64'd0);
    chk("ar_zero", {63'd0, rsp_zero}, 64'd0);
    chk("ar_data1", alu_data1, 64'd0);
    chk("ar_alu_op", {60'd0, alu_op}, 64'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_no_late_rsp", {62'd0, rsp_valid}, 64'd0);
    run_op(0, 64'd10, 64'd20, 4'b0010, 64'd30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
